p405s_itlb_refillctl: RTL

Refill controller for the four-entry instruction shadow TLB. It consumes the per-entry Hit/Miss results of the shadow-TLB words and, on a qualified miss, requests a translation from the unified TLB. It then writes the returned RPN/EPN/size/attributes into a round-robin victim entry by driving that entry's WordSel_N, writeShadow and data inputs. It also sequences whole-array invalidation for context-synchronising events.

---
 rtl/p405s_itlb_refillctl_if.sv | 61 ++++++
 rtl/p405s_itlb_refillctl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/p405s_itlb_refillctl_if.sv
`default_nettype none
// ============================================================================
// Module      : p405s_itlb_refillctl_if
// Description : Bundle of the fetch-side miss inputs, the UTLB request and
//               response handshake and the shadow-TLB write port used by the
//               ITLB refill controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface p405s_itlb_refillctl_if;

    // Fetch side: miss indication and the effective page address
    logic        isMiss;
    logic        isAbort_N;
    logic [0:21] isEA;
    logic        invalAll;

    // UTLB handshake and response payload
    logic        utlbReq;
    logic [0:21] utlbEA;
    logic        utlbGnt;
    logic        utlbRdy;
    logic        utlbFault;
    logic [0:21] utlbRPN;
    logic [0:6]  utlbDSize;
    logic        utlbI;
    logic        utlbE;
    logic        utlbU0;

    // Shadow-TLB write port and status
    logic [0:3]  WordSel_N;
    logic        writeShadow;
    logic        invalidate;
    logic [0:21] isEPN;
    logic [0:6]  DSize;
    logic [0:21] RPN;
    logic        I;
    logic        E;
    logic        U0;
    logic        refillBusy;
    logic        itlbFault;

    // Refill controller side
    modport master (
        input  isMiss, isAbort_N, isEA, invalAll,
               utlbGnt, utlbRdy, utlbFault, utlbRPN, utlbDSize,
               utlbI, utlbE, utlbU0,
        output utlbReq, utlbEA, WordSel_N, writeShadow, invalidate, isEPN,
               DSize, RPN, I, E, U0, refillBusy, itlbFault
    );

    // Environment side (fetch unit, UTLB and shadow array)
    modport slave (
        output isMiss, isAbort_N, isEA, invalAll,
               utlbGnt, utlbRdy, utlbFault, utlbRPN, utlbDSize,
               utlbI, utlbE, utlbU0,
        input  utlbReq, utlbEA, WordSel_N, writeShadow, invalidate, isEPN,
               DSize, RPN, I, E, U0, refillBusy, itlbFault
    );

endinterface
`default_nettype wire

// File: rtl/p405s_itlb_refillctl.sv
`default_nettype none
// ============================================================================
// Module      : p405s_itlb_refillctl
// Description : Refill controller for the four-entry instruction shadow TLB.
//               On a qualified miss it requests a translation from the
//               unified TLB and writes the response into a round-robin
//               victim entry; it also sequences whole-array invalidation.
//               Every output is a flop, so there is no input-to-output path.
// Revision    : 1.0 - initial release
// ============================================================================
module p405s_itlb_refillctl (
    input  logic                   CB,
    input  logic                   reset_N,
    p405s_itlb_refillctl_if.master itlb
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_WRITE = 3'd4,
        S_INVAL = 3'd5,
        S_FAULT = 3'd6
    } state_t;

    state_t      r_state;
    logic [1:0]  r_victim;
    logic        r_pend_inval;

    // Registered strobes and status
    logic        r_utlb_req;
    logic [0:3]  r_word_sel_n;
    logic        r_write_shadow;
    logic        r_invalidate;
    logic        r_refill_busy;
    logic        r_itlb_fault;

    // Latched miss address and UTLB response
    logic [0:21] r_ea;
    logic [0:21] r_rpn;
    logic [0:6]  r_dsize;
    logic        r_i;
    logic        r_e;
    logic        r_u0;

    // Controller FSM. Outputs are registered alongside the state they belong
    // to, so each transition also loads the output values of the target state.
    always_ff @(posedge CB or negedge reset_N) begin
        if (!reset_N) begin
            r_state        <= S_IDLE;
            r_victim       <= 2'd0;
            r_pend_inval   <= 1'b0;
            r_utlb_req     <= 1'b0;
            r_word_sel_n   <= 4'b1111;
            r_write_shadow <= 1'b0;
            r_invalidate   <= 1'b0;
            r_refill_busy  <= 1'b0;
            r_itlb_fault   <= 1'b0;
            r_ea           <= '0;
            r_rpn          <= '0;
            r_dsize        <= '0;
            r_i            <= 1'b0;
            r_e            <= 1'b0;
            r_u0           <= 1'b0;
        end else begin
            // Strobes fall unless the target state raises them; busy stays
            // high and is cleared only by a transition into IDLE.
            r_utlb_req     <= 1'b0;
            r_word_sel_n   <= 4'b1111;
            r_write_shadow <= 1'b0;
            r_invalidate   <= 1'b0;
            r_itlb_fault   <= 1'b0;
            r_refill_busy  <= 1'b1;

            unique case (r_state)
                S_IDLE: begin
                    // Invalidation wins; a simultaneous miss is dropped and
                    // will be re-presented by the fetch unit.
                    if (itlb.invalAll) begin
                        r_state      <= S_INVAL;
                        r_invalidate <= 1'b1;
                    end else if (itlb.isMiss && itlb.isAbort_N) begin
                        r_ea       <= itlb.isEA;
                        r_state    <= S_REQ;
                        r_utlb_req <= 1'b1;
                    end else begin
                        r_refill_busy <= 1'b0;
                    end
                end

                S_REQ: begin
                    if (itlb.invalAll) begin
                        r_state      <= S_INVAL;
                        r_invalidate <= 1'b1;
                    end else if (!itlb.isAbort_N) begin
                        r_state       <= S_IDLE;
                        r_refill_busy <= 1'b0;
                    end else if (itlb.utlbGnt) begin
                        r_state <= S_WAIT;
                    end else begin
                        r_utlb_req <= 1'b1;
                    end
                end

                S_WAIT: begin
                    if (!itlb.isAbort_N || itlb.invalAll) begin
                        // A response landing in the same cycle is consumed
                        // here, otherwise DRAIN would wait for a response
                        // that has already gone by.
                        if (itlb.utlbRdy) begin
                            if (itlb.invalAll || r_pend_inval) begin
                                r_state      <= S_INVAL;
                                r_invalidate <= 1'b1;
                            end else begin
                                r_state       <= S_IDLE;
                                r_refill_busy <= 1'b0;
                            end
                        end else begin
                            r_state      <= S_DRAIN;
                            r_pend_inval <= r_pend_inval | itlb.invalAll;
                        end
                    end else if (itlb.utlbRdy) begin
                        if (itlb.utlbFault) begin
                            r_state      <= S_FAULT;
                            r_itlb_fault <= 1'b1;
                        end else begin
                            r_rpn          <= itlb.utlbRPN;
                            r_dsize        <= itlb.utlbDSize;
                            r_i            <= itlb.utlbI;
                            r_e            <= itlb.utlbE;
                            r_u0           <= itlb.utlbU0;
                            r_state        <= S_WRITE;
                            r_word_sel_n   <= ~(4'b1000 >> r_victim);
                            r_write_shadow <= 1'b1;
                        end
                    end
                end

                S_DRAIN: begin
                    // Absorb the outstanding response without writing it
                    if (itlb.invalAll) begin
                        r_pend_inval <= 1'b1;
                    end
                    if (itlb.utlbRdy) begin
                        if (r_pend_inval || itlb.invalAll) begin
                            r_state      <= S_INVAL;
                            r_invalidate <= 1'b1;
                        end else begin
                            r_state       <= S_IDLE;
                            r_refill_busy <= 1'b0;
                        end
                    end
                end

                S_WRITE: begin
                    // The write strobe was already issued; advance the victim
                    r_victim <= r_victim + 2'd1;
                    if (itlb.invalAll) begin
                        r_state      <= S_INVAL;
                        r_invalidate <= 1'b1;
                    end else begin
                        r_state       <= S_IDLE;
                        r_refill_busy <= 1'b0;
                    end
                end

                S_INVAL: begin
                    // Victim pointer deliberately survives invalidation
                    r_pend_inval  <= 1'b0;
                    r_state       <= S_IDLE;
                    r_refill_busy <= 1'b0;
                end

                S_FAULT: begin
                    r_state       <= S_IDLE;
                    r_refill_busy <= 1'b0;
                end

                default: begin
                    r_state       <= S_IDLE;
                    r_refill_busy <= 1'b0;
                end
            endcase
        end
    end

    assign itlb.utlbReq     = r_utlb_req;
    assign itlb.utlbEA      = r_ea;
    assign itlb.isEPN       = r_ea;
    assign itlb.WordSel_N   = r_word_sel_n;
    assign itlb.writeShadow = r_write_shadow;
    assign itlb.invalidate  = r_invalidate;
    assign itlb.refillBusy  = r_refill_busy;
    assign itlb.itlbFault   = r_itlb_fault;
    assign itlb.RPN         = r_rpn;
    assign itlb.DSize       = r_dsize;
    assign itlb.I           = r_i;
    assign itlb.E           = r_e;
    assign itlb.U0          = r_u0;

endmodule
`default_nettype wire
